// File: rtl/key_pkg.sv
// Shared constants for the key conditioner.
// Holds the default key count, the key index map and a counter-width helper.
package key_pkg;

    localparam int NUM_KEYS = 12;

    localparam int KEY_IDX_1     = 0;
    localparam int KEY_IDX_2     = 1;
    localparam int KEY_IDX_3     = 2;
    localparam int KEY_IDX_4     = 3;
    localparam int KEY_IDX_5     = 4;
    localparam int KEY_IDX_6     = 5;
    localparam int KEY_IDX_7     = 6;
    localparam int KEY_IDX_8     = 7;
    localparam int KEY_IDX_9     = 8;
    localparam int KEY_IDX_STAR  = 9;
    localparam int KEY_IDX_0     = 10;
    localparam int KEY_IDX_SHARP = 11;

    // Bits needed for a counter that must hold the value n itself.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// Per-key conditioning cell.
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   sample_tick_i one-clk debounce sample strobe from the shared prescaler
//   key_raw_i     asynchronous raw key level
//   level_o       debounced key level
//   press_o       one-clk pulse on accepted 0->1
//   release_o     one-clk pulse on accepted 1->0
//   long_o        one-clk pulse once the key has been held LONG_SAMPLES samples
module key_debounce_cell
    import key_pkg::*;
#(
    parameter int DB_SAMPLES   = 8,
    parameter int LONG_SAMPLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_tick_i,
    input  logic key_raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam int DBW = cnt_width(DB_SAMPLES);
    localparam int HW  = cnt_width(LONG_SAMPLES);

    localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_SAMPLES - 1);
    localparam logic [HW-1:0]  HOLD_MAX  = HW'(LONG_SAMPLES);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(LONG_SAMPLES - 1);

    logic           sync1_q, sync2_q;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic           level_q, level_d;
    logic           press_q, press_d;
    logic           release_q, release_d;
    logic           long_q, long_d;

    always_comb begin
        db_cnt_d  = db_cnt_q;
        level_d   = level_q;
        hold_d    = hold_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;

        if (sample_tick_i) begin
            if (sync2_q != level_q) begin
                // The sample that would make the count reach DB_SAMPLES flips the level.
                if (db_cnt_q == DB_LAST) begin
                    level_d   = ~level_q;
                    db_cnt_d  = '0;
                    press_d   = ~level_q;
                    release_d = level_q;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end else begin
                db_cnt_d = '0;
            end
        end

        // Hold counting stops on the tick that accepts a release, so a long
        // pulse can never coincide with the release pulse.
        if (!level_q) begin
            hold_d = '0;
        end else if (sample_tick_i && !release_d && (hold_q != HOLD_MAX)) begin
            hold_d = hold_q + 1'b1;
            long_d = (hold_q == HOLD_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            db_cnt_q  <= '0;
            hold_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            sync1_q   <= key_raw_i;
            sync2_q   <= sync1_q;
            db_cnt_q  <= db_cnt_d;
            hold_q    <= hold_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;

endmodule

// File: rtl/key_conditioner.sv
// Keypad conditioner: synchronises, debounces and classifies NUM_KEYS keys.
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   key_raw      asynchronous raw key levels (index map in key_pkg)
//   key_level    debounced key levels
//   key_press    one-clk pulse per accepted press
//   key_release  one-clk pulse per accepted release
//   key_long     one-clk pulse per press held LONG_SAMPLES samples
//   any_key      OR of key_level
module key_conditioner
    import key_pkg::*;
#(
    parameter int NUM_KEYS     = key_pkg::NUM_KEYS,
    parameter int SAMPLE_DIV   = 50000,
    parameter int DB_SAMPLES   = 8,
    parameter int LONG_SAMPLES = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long,
    output logic                any_key
);

    localparam int PW = cnt_width(SAMPLE_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(SAMPLE_DIV - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic          sample_tick;

    assign sample_tick = (pre_q == PRE_LAST);

    always_comb begin
        pre_d = sample_tick ? '0 : pre_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce_cell #(
            .DB_SAMPLES   (DB_SAMPLES),
            .LONG_SAMPLES (LONG_SAMPLES)
        ) u_cell (
            .clk           (clk),
            .rst           (rst),
            .sample_tick_i (sample_tick),
            .key_raw_i     (key_raw[k]),
            .level_o       (key_level[k]),
            .press_o       (key_press[k]),
            .release_o     (key_release[k]),
            .long_o        (key_long[k])
        );
    end

    assign any_key = |key_level;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with SAMPLE_DIV=4, DB_SAMPLES=3, LONG_SAMPLES=10.
module tb_key_conditioner;

    localparam int NK = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic [NK-1:0] key_raw;
    logic [NK-1:0] key_level, key_press, key_release, key_long;
    logic          any_key;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    int press_cnt [NK];
    int rel_cnt   [NK];
    int long_cnt  [NK];
    int press_cyc [NK];
    int long_cyc  [NK];
    int excl_viol = 0;
    int lvl9_seen = 0;

    key_conditioner #(
        .NUM_KEYS     (NK),
        .SAMPLE_DIV   (4),
        .DB_SAMPLES   (3),
        .LONG_SAMPLES (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_raw     (key_raw),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long),
        .any_key     (any_key)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < NK; i++) begin
            press_cnt[i] = 0; rel_cnt[i] = 0; long_cnt[i] = 0;
            press_cyc[i] = 0; long_cyc[i] = 0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NK; i++) begin
            if (key_press[i])   begin press_cnt[i]++; press_cyc[i] = cyc; end
            if (key_release[i]) rel_cnt[i]++;
            if (key_long[i])    begin long_cnt[i]++; long_cyc[i] = cyc; end
            if (int'(key_press[i]) + int'(key_release[i]) + int'(key_long[i]) > 1) excl_viol++;
        end
        if (key_level[9]) lvl9_seen++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int sum(input int a [NK]);
        int s = 0;
        for (int i = 0; i < NK; i++) s += a[i];
        return s;
    endfunction

    int t0;

    initial begin
        rst     = 1'b1;
        key_raw = '0;
        step(4);

        check("rst_level",   32'(key_level),   32'h0);
        check("rst_press",   32'(key_press),   32'h0);
        check("rst_release", 32'(key_release), 32'h0);
        check("rst_long",    32'(key_long),    32'h0);
        check("rst_any",     32'(any_key),     32'h0);

        rst = 1'b0;
        step(3);

        // Clean press on bit 0
        key_raw[0] = 1'b1;
        t0 = cyc;
        step(30);
        check("press0_level", 32'(key_level), 32'h001);
        check("press0_cnt",   press_cnt[0], 1);
        check("press0_lat_ok", 32'((press_cyc[0] - t0 >= 10) && (press_cyc[0] - t0 <= 14)), 1);
        check("press0_total", sum(press_cnt), 1);
        key_raw[0] = 1'b0;
        step(30);
        check("rel0_level", 32'(key_level), 32'h0);
        check("rel0_cnt",   rel_cnt[0], 1);
        check("rel0_long",  long_cnt[0], 0);

        // Bounce on bit 9: high for 2 samples, low for 2 samples, five times
        for (int r = 0; r < 5; r++) begin
            key_raw[9] = 1'b1;
            step(8);
            key_raw[9] = 1'b0;
            step(8);
        end
        step(20);
        check("bounce_lvl_seen", lvl9_seen, 0);
        check("bounce_press",    sum(press_cnt), 1);
        check("bounce_release",  sum(rel_cnt), 1);
        check("bounce_level",    32'(key_level), 32'h0);

        // Long hold on bit 11
        key_raw[11] = 1'b1;
        step(60);
        key_raw[11] = 1'b0;
        step(30);
        check("long11_press",   press_cnt[11], 1);
        check("long11_long",    long_cnt[11], 1);
        check("long11_delay",   long_cyc[11] - press_cyc[11], 40);
        check("long11_release", rel_cnt[11], 1);
        step(60);
        check("long11_no_more", long_cnt[11], 1);

        // Simultaneous press on bits 2 and 7
        key_raw[2] = 1'b1;
        key_raw[7] = 1'b1;
        step(30);
        check("sim_press2",  press_cnt[2], 1);
        check("sim_press7",  press_cnt[7], 1);
        check("sim_samecyc", press_cyc[2] - press_cyc[7], 0);
        check("sim_level",   32'(key_level), 32'h084);
        key_raw[2] = 1'b0;
        step(30);
        check("sim_any_one", 32'(any_key), 32'h1);
        check("sim_level7",  32'(key_level), 32'h080);
        key_raw[7] = 1'b0;
        step(30);
        check("sim_any_none", 32'(any_key), 32'h0);

        // Reset mid-hold on bit 5
        key_raw[5] = 1'b1;
        step(20);
        check("mid_press1", press_cnt[5], 1);
        for (int g = 0; g < 40 && cyc < press_cyc[5] + 25; g++) step(1);
        check("mid_hold6_reached", 32'(cyc == press_cyc[5] + 25), 1);
        rst = 1'b1;
        step(2);
        check("mid_rst_level", 32'(key_level), 32'h0);
        check("mid_rst_pulse", 32'(key_press | key_release | key_long), 32'h0);
        check("mid_rst_any",   32'(any_key), 32'h0);
        step(1);
        rst = 1'b0;
        t0 = cyc;
        step(30);
        check("mid_press2",  press_cnt[5], 2);
        check("mid_lat_ok",  32'((press_cyc[5] - t0 >= 10) && (press_cyc[5] - t0 <= 14)), 1);
        check("mid_no_long_yet", long_cnt[5], 0);
        step(30);
        check("mid_long",    long_cnt[5], 1);
        check("mid_long_dly", long_cyc[5] - press_cyc[5], 40);
        key_raw[5] = 1'b0;
        step(30);
        check("mid_release", rel_cnt[5], 1);
        check("mid_level",   32'(key_level), 32'h0);

        check("exclusive", excl_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 Parameter NUM_KEYS, default 12, number of conditioned key inputs.
REQ-002 Parameter SAMPLE_DIV, default 50000, clk cycles per debounce sample tick (1 ms at 50 MHz).
REQ-003 Parameter DB_SAMPLES, default 8, consecutive disagreeing samples needed to accept a level change.
REQ-004 Parameter LONG_SAMPLES, default 1000, consecutive held samples, counted after acceptance, before a long-press pulse.
REQ-005 clk  input  1  system clock; the block uses one clock.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 key_raw  input  NUM_KEYS  asynchronous active-high key levels; bit 0..8 = KEY_1..KEY_9, 9 = KEY_STAR, 10 = KEY_0, 11 = KEY_SHARP.
REQ-008 key_level  output  NUM_KEYS  debounced stable key level.
REQ-009 key_press  output  NUM_KEYS  one-clk pulse on accepted 0->1 transition.
REQ-010 key_release  output  NUM_KEYS  one-clk pulse on accepted 1->0 transition.
REQ-011 key_long  output  NUM_KEYS  one-clk pulse when a key has been held LONG_SAMPLES samples.
REQ-012 any_key  output  1  OR-reduction of key_level.

Function
REQ-013 Each key_raw bit SHALL pass a 2-flop synchronizer before any other use.
REQ-014 A free-running prescaler SHALL count 0..SAMPLE_DIV-1 and assert sample_tick for one clk when it reaches SAMPLE_DIV-1, then wrap to 0.
REQ-015 Per key, on sample_tick: synced value != key_level increments db_cnt; synced value == key_level clears db_cnt to 0.
REQ-016 When db_cnt would reach DB_SAMPLES, key_level SHALL toggle, db_cnt SHALL clear, and the matching key_press or key_release SHALL pulse high in the following clk only.
REQ-017 A glitch shorter than DB_SAMPLES consecutive samples SHALL produce no change in any output.
REQ-018 Per key, hold_cnt SHALL increment on each sample_tick while key_level = 1, saturate at LONG_SAMPLES, and clear when key_level = 0.
REQ-019 key_long SHALL pulse exactly once per press, one clk after hold_cnt reaches LONG_SAMPLES; it SHALL never pulse after a release without a new press.
REQ-020 Keys SHALL be fully independent; simultaneous transitions on several keys SHALL pulse all affected bits in the same clk.
REQ-021 Press-to-key_press latency SHALL be between 2 + (DB_SAMPLES-1)*SAMPLE_DIV + 1 and 2 + DB_SAMPLES*SAMPLE_DIV + 1 clk for a clean edge.
REQ-022 Counter widths SHALL be $clog2(param+1); no counter SHALL wrap except the prescaler.
REQ-023 key_press, key_release and key_long SHALL never be high at the same time for the same bit.

Reset
REQ-024 While rst = 1: synchronizers, prescaler, db_cnt, hold_cnt and all outputs SHALL be 0.
REQ-025 A key held through reset release SHALL be treated as a new press: key_press follows after DB_SAMPLES samples.
REQ-026 A reset asserted mid-debounce or mid-hold SHALL discard the partial count; no pulse SHALL be emitted for it.

Structure
REQ-027 Shared package key_pkg SHALL hold NUM_KEYS and the key index constants (KEY_IDX_1 .. KEY_IDX_SHARP).
REQ-028 Per-key logic (synchronizer, db_cnt, hold_cnt, pulse regs) SHALL live in sub-module key_debounce_cell, instantiated NUM_KEYS times; the prescaler stays in key_conditioner.

Verification (SAMPLE_DIV=4, DB_SAMPLES=3, LONG_SAMPLES=10)
REQ-029 Clean press: bit 0 raised and held -> key_level[0]=1 and one key_press[0] pulse, 10..14 clk after the edge; no other bit moves.
REQ-030 Bounce: bit 9 toggled high for 2 samples then low, repeated 5 times -> key_level, key_press and key_release stay 0.
REQ-031 Long hold: bit 11 held 60 clk -> one key_press[11], then exactly one key_long[11] after 10 further samples; release -> one key_release[11] and no further key_long pulses.
REQ-032 Simultaneous: bits 2 and 7 raised in the same clk -> key_press[2] and key_press[7] pulse in the same clk; any_key=1 until both are released.
REQ-033 Reset mid-operation: rst pulsed while bit 5 held with hold_cnt=6 -> all outputs 0 during reset; after release, key_press[5] after 3 samples, key_long[5] 10 samples after that.
